// File: rtl/z80_daisy_ctrl_pkg.sv
// Shared opcode constants and decoder state codes for the Z80 daisy-chain controller.
package z80_daisy_ctrl_pkg;

  localparam logic [7:0] OP_CB   = 8'hCB;
  localparam logic [7:0] OP_ED   = 8'hED;
  localparam logic [7:0] OP_RETI = 8'h4D;
  localparam logic [7:0] OP_RETN = 8'h45;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CB   = 2'd1,
    S_ED   = 2'd2
  } retx_state_e;

endpackage

// File: rtl/z80_daisy_ctrl_if.sv
// CPU snoop, peripheral request and daisy-chain signals of the interrupt controller.
interface z80_daisy_ctrl_if #(
  parameter int NUM_CH = 4
) ();

  logic                  I_CLKEN;
  logic                  I_M1_n;
  logic                  I_MREQ_n;
  logic                  I_IORQ_n;
  logic [7:0]            I_D;
  logic [NUM_CH-1:0]     I_IRQ;
  logic [8*NUM_CH-1:0]   I_VEC;
  logic                  I_IEI;
  logic                  O_IEO;
  logic                  O_INT_n;
  logic [7:0]            O_VEC;
  logic                  O_VEC_OE;
  logic [NUM_CH-1:0]     O_IUS;
  logic                  O_RETI;
  logic                  O_RETN;

  modport slave (
    input  I_CLKEN, I_M1_n, I_MREQ_n, I_IORQ_n, I_D, I_IRQ, I_VEC, I_IEI,
    output O_IEO, O_INT_n, O_VEC, O_VEC_OE, O_IUS, O_RETI, O_RETN
  );

  modport master (
    output I_CLKEN, I_M1_n, I_MREQ_n, I_IORQ_n, I_D, I_IRQ, I_VEC, I_IEI,
    input  O_IEO, O_INT_n, O_VEC, O_VEC_OE, O_IUS, O_RETI, O_RETN
  );

endinterface

// File: rtl/z80_daisy_ctrl_retx_decoder.sv
// Snoops M1 opcode fetches and emits one-CLKEN pulses for RETI (ED 4D) and RETN (ED 45).
module z80_daisy_ctrl_retx_decoder
  import z80_daisy_ctrl_pkg::*;
#(
  parameter bit DETECT_RETN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clken_i,
  input  logic       fetch_i,
  input  logic [7:0] d_i,
  output logic       reti_o,
  output logic       retn_o
);

  logic        fetch_q;
  logic [7:0]  op_q;
  retx_state_e state_q, state_d;
  logic        reti_q, reti_d;
  logic        retn_q, retn_d;
  logic        fetch_end;

  // The last byte sampled during the fetch is the opcode; it is judged once M1/MREQ release.
  assign fetch_end = fetch_q & ~fetch_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_q <= 1'b0;
      op_q    <= 8'h00;
      state_q <= S_IDLE;
      reti_q  <= 1'b0;
      retn_q  <= 1'b0;
    end else if (clken_i) begin
      fetch_q <= fetch_i;
      if (fetch_i) begin
        op_q <= d_i;
      end
      state_q <= state_d;
      reti_q  <= reti_d;
      retn_q  <= retn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reti_d  = 1'b0;
    retn_d  = 1'b0;
    if (fetch_end) begin
      case (state_q)
        S_IDLE: begin
          if (op_q == OP_CB) begin
            state_d = S_CB;
          end else if (op_q == OP_ED) begin
            state_d = S_ED;
          end
        end
        S_CB: state_d = S_IDLE;
        // A second ED is an opcode byte here, so it returns to idle rather than re-priming.
        S_ED: begin
          reti_d  = (op_q == OP_RETI);
          retn_d  = DETECT_RETN && (op_q == OP_RETN);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign reti_o = reti_q;
  assign retn_o = retn_q;

endmodule

// File: rtl/z80_daisy_ctrl.sv
// Z80 mode-2 daisy-chain interrupt controller: pending/in-service tracking, priority, IM2 vector.
module z80_daisy_ctrl
  import z80_daisy_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter bit DETECT_RETN = 1'b1
) (
  input  logic I_CLK,
  input  logic I_RESET_n,
  z80_daisy_ctrl_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              fetch, inta, inta_q, inta_rise;
  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ius_q, ius_d;
  logic              oe_q, oe_d;
  logic [CH_W-1:0]   winner_q, winner_d;
  logic [NUM_CH-1:0] chain_en, req, win_mask, ius_low;
  logic [CH_W-1:0]   win_idx;
  logic [7:0]        vec_arr [NUM_CH];
  logic              reti, retn;

  assign fetch     = ~bus.I_M1_n & ~bus.I_MREQ_n;
  assign inta      = ~bus.I_M1_n & ~bus.I_IORQ_n;
  assign inta_rise = inta & ~inta_q;

  z80_daisy_ctrl_retx_decoder #(
    .DETECT_RETN(DETECT_RETN)
  ) u_retx (
    .clk_i   (I_CLK),
    .rst_ni  (I_RESET_n),
    .clken_i (bus.I_CLKEN),
    .fetch_i (fetch),
    .d_i     (bus.I_D),
    .reti_o  (reti),
    .retn_o  (retn)
  );

  // A channel may request only while no higher-priority channel (or upstream device) is in service.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign chain_en[gi] = bus.I_IEI;
      end else begin : g_rest
        assign chain_en[gi] = bus.I_IEI & ~|ius_q[gi-1:0];
      end
      assign vec_arr[gi] = bus.I_VEC[8*gi +: 8];
    end
  endgenerate

  assign req = chain_en & ~ius_q & pend_q;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = CH_W'(i);
      end
    end
  end

  assign win_mask = NUM_CH'(1) << win_idx;
  assign ius_low  = ius_q & (~ius_q + NUM_CH'(1));

  always_comb begin
    pend_d   = pend_q;
    ius_d    = ius_q;
    oe_d     = oe_q;
    winner_d = winner_q;
    if (reti && bus.I_IEI) begin
      ius_d = ius_q & ~ius_low;
    end
    if (inta_rise && (|req)) begin
      ius_d    = ius_d | win_mask;
      pend_d   = pend_d & ~win_mask;
      oe_d     = 1'b1;
      winner_d = win_idx;
    end else if (!inta) begin
      oe_d = 1'b0;
    end
    // A new request edge arriving with the acknowledge keeps the channel pending.
    pend_d = pend_d | (bus.I_IRQ & ~irq_q);
  end

  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      inta_q   <= 1'b0;
      irq_q    <= '0;
      pend_q   <= '0;
      ius_q    <= '0;
      oe_q     <= 1'b0;
      winner_q <= '0;
    end else if (bus.I_CLKEN) begin
      inta_q   <= inta;
      irq_q    <= bus.I_IRQ;
      pend_q   <= pend_d;
      ius_q    <= ius_d;
      oe_q     <= oe_d;
      winner_q <= winner_d;
    end
  end

  // The bus is released as soon as the CPU ends the acknowledge, not at the next CLKEN.
  assign bus.O_VEC_OE = oe_q & inta;
  assign bus.O_VEC    = bus.O_VEC_OE ? vec_arr[winner_q] : 8'h00;
  assign bus.O_INT_n  = ~|req;
  assign bus.O_IEO    = bus.I_IEI & ~|ius_q & ~((|pend_q) & ~bus.I_M1_n);
  assign bus.O_IUS    = ius_q;
  assign bus.O_RETI   = reti;
  assign bus.O_RETN   = retn;

endmodule

// File: tb/tb_z80_daisy_ctrl.sv
// Directed and randomized checks of z80_daisy_ctrl against an instruction-stream / priority model.
module tb_z80_daisy_ctrl;

  localparam int NUM_CH      = 4;
  localparam bit DETECT_RETN = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  z80_daisy_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

  z80_daisy_ctrl #(
    .NUM_CH      (NUM_CH),
    .DETECT_RETN (DETECT_RETN)
  ) dut (
    .I_CLK     (clk),
    .I_RESET_n (rst_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] vec_tab [NUM_CH];
  bit         m_pend  [NUM_CH];
  bit         m_ius   [NUM_CH];
  logic [7:0] hist    [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Interrupt that would be acknowledged now: walk the chain from the highest priority.
  function automatic int m_winner();
    if (!bus.I_IEI) return -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_ius[i]) return -1;
      if (m_pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] m_ius_vec();
    logic [NUM_CH-1:0] v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_ius[i];
    return v;
  endfunction

  function automatic logic m_ieo();
    bit any_ius = 0, any_pend = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      any_ius  |= m_ius[i];
      any_pend |= m_pend[i];
    end
    return bus.I_IEI && !any_ius && !(any_pend && !bus.I_M1_n);
  endfunction

  // Parse the whole opcode history as instructions; report RETI/RETN if the last byte ends one.
  function automatic logic [1:0] parse_tail();
    int n = hist.size();
    int i = 0;
    logic [1:0] r = 2'b00;
    while (i < n) begin
      if (hist[i] == 8'hCB || hist[i] == 8'hED) begin
        if (hist[i] == 8'hED && i + 1 == n - 1) begin
          r[0] = (hist[i+1] == 8'h4D);
          r[1] = DETECT_RETN && (hist[i+1] == 8'h45);
        end
        i += 2;
      end else begin
        i += 1;
      end
    end
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 0;
      m_ius[i]  = 0;
    end
    hist.delete();
  endtask

  task automatic ce(input int n);
    repeat (n) begin
      bus.I_CLKEN = 1'b1;
      @(negedge clk);
      bus.I_CLKEN = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
  endtask

  task automatic check_static(input string tag);
    check({tag, "_int_n"}, bus.O_INT_n, (m_winner() >= 0) ? 1'b0 : 1'b1);
    check({tag, "_ius"},   bus.O_IUS,   m_ius_vec());
    check({tag, "_ieo"},   bus.O_IEO,   m_ieo());
  endtask

  task automatic fetch(input logic [7:0] b);
    logic [1:0] exp;
    bus.I_M1_n = 1'b0; bus.I_MREQ_n = 1'b0; bus.I_D = b;
    ce(2);
    bus.I_M1_n = 1'b1; bus.I_MREQ_n = 1'b1; bus.I_D = 8'($urandom);
    ce(1);
    hist.push_back(b);
    exp = parse_tail();
    check("reti_pulse", bus.O_RETI, exp[0]);
    check("retn_pulse", bus.O_RETN, exp[1]);
    ce(1);
    check("reti_width", bus.O_RETI, 1'b0);
    check("retn_width", bus.O_RETN, 1'b0);
    if (exp[0] && bus.I_IEI) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_ius[i]) begin
          m_ius[i] = 0;
          break;
        end
      end
    end
    check("fetch_ius", bus.O_IUS, m_ius_vec());
    $display("fetch %02h iei=%0d reti=%0d retn=%0d ius=%b", b, bus.I_IEI, exp[0], exp[1], bus.O_IUS);
  endtask

  task automatic inta();
    int w;
    bus.I_M1_n = 1'b0;
    ce(1);
    check("m1_ieo", bus.O_IEO, m_ieo());
    w = m_winner();
    bus.I_IORQ_n = 1'b0;
    ce(1);
    if (w >= 0) begin
      m_ius[w]  = 1;
      m_pend[w] = 0;
    end
    check("ack_oe",  bus.O_VEC_OE, (w >= 0) ? 1'b1 : 1'b0);
    check("ack_vec", bus.O_VEC,    (w >= 0) ? vec_tab[w] : 8'h00);
    ce(1);
    check("ack_oe_hold", bus.O_VEC_OE, (w >= 0) ? 1'b1 : 1'b0);
    check("ack_ius", bus.O_IUS, m_ius_vec());
    bus.I_IORQ_n = 1'b1; bus.I_M1_n = 1'b1;
    #1;
    check("ack_oe_rel",  bus.O_VEC_OE, 1'b0);
    check("ack_vec_rel", bus.O_VEC,    8'h00);
    ce(1);
    $display("inta winner=%0d vec=%02h ius=%b", w, (w >= 0) ? vec_tab[w] : 8'h00, bus.O_IUS);
  endtask

  task automatic irq(input logic [NUM_CH-1:0] m);
    bus.I_IRQ = m;
    ce(2);
    bus.I_IRQ = '0;
    ce(1);
    for (int i = 0; i < NUM_CH; i++) if (m[i]) m_pend[i] = 1;
    $display("irq %b", m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [6];
    ops = '{8'h00, 8'hCB, 8'hED, 8'h4D, 8'h45, 8'h3E};

    bus.I_CLKEN = 1'b0; bus.I_M1_n = 1'b1; bus.I_MREQ_n = 1'b1; bus.I_IORQ_n = 1'b1;
    bus.I_D = 8'h00; bus.I_IRQ = '0; bus.I_IEI = 1'b1;
    for (int i = 0; i < NUM_CH; i++) vec_tab[i] = 8'(8'h10 * i + $urandom_range(0, 15)) & 8'hFE;
    bus.I_VEC = {vec_tab[3], vec_tab[2], vec_tab[1], vec_tab[0]};
    m_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_int_n", bus.O_INT_n,  1'b1);
    check("rst_oe",    bus.O_VEC_OE, 1'b0);
    check("rst_vec",   bus.O_VEC,    8'h00);
    check("rst_ius",   bus.O_IUS,    4'b0000);
    check("rst_reti",  bus.O_RETI,   1'b0);
    check("rst_retn",  bus.O_RETN,   1'b0);
    check("rst_ieo1",  bus.O_IEO,    1'b1);
    bus.I_IEI = 1'b0; #1;
    check("rst_ieo0",  bus.O_IEO,    1'b0);
    bus.I_IEI = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RETI decode and prefix handling
    fetch(8'h00); fetch(8'hED); fetch(8'h4D);
    fetch(8'hCB); fetch(8'hED); fetch(8'h4D);
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    fetch(8'hED); fetch(8'h45);

    // Acknowledge picks ch1 over ch2; ch2 then blocked by IUS1
    irq(4'b0110);
    check_static("t3_pre");
    inta();
    check_static("t3_post");
    check("t3_ius", bus.O_IUS, 4'b0010);

    // Build IUS=0110 by nesting, then RETI behaviour against IEI
    fetch(8'hED); fetch(8'h4D);
    inta();
    irq(4'b0010);
    inta();
    check("t4_ius", bus.O_IUS, 4'b0110);
    fetch(8'hED); fetch(8'h4D);
    check("t4_reti", bus.O_IUS, 4'b0100);
    check_static("t4a");
    bus.I_IEI = 1'b0;
    fetch(8'hED); fetch(8'h4D);
    check("t4_iei0", bus.O_IUS, 4'b0100);
    bus.I_IEI = 1'b1;
    fetch(8'hED); fetch(8'h4D);
    check_static("t4b");

    // Chain gating by IEI and M1 freeze
    bus.I_IEI = 1'b0;
    irq(4'b0001);
    check_static("t5_iei0");
    bus.I_IEI = 1'b1; #1;
    check("t5_int_n", bus.O_INT_n, 1'b0);
    bus.I_M1_n = 1'b0; #1;
    check("t5_m1_ieo", bus.O_IEO, 1'b0);
    bus.I_M1_n = 1'b1;
    @(negedge clk);
    inta();
    fetch(8'hED); fetch(8'h4D);
    check_static("t5_done");

    // Reset in the middle of an acknowledge
    irq(4'b0100);
    bus.I_M1_n = 1'b0; bus.I_IORQ_n = 1'b0;
    ce(2);
    check("t6_oe_pre", bus.O_VEC_OE, 1'b1);
    rst_n = 1'b0; #1;
    check("t6_oe",    bus.O_VEC_OE, 1'b0);
    check("t6_vec",   bus.O_VEC,    8'h00);
    check("t6_ius",   bus.O_IUS,    4'b0000);
    check("t6_reti",  bus.O_RETI,   1'b0);
    check("t6_int_n", bus.O_INT_n,  1'b1);
    m_clear();
    bus.I_M1_n = 1'b1; bus.I_IORQ_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ED 4D fetched with CLKEN held low is invisible to the block
    irq(4'b0001);
    inta();
    bus.I_CLKEN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.I_M1_n = 1'b0; bus.I_MREQ_n = 1'b0; bus.I_D = (k == 0) ? 8'hED : 8'h4D;
      repeat (3) @(negedge clk);
      bus.I_M1_n = 1'b1; bus.I_MREQ_n = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_ce_reti", bus.O_RETI, 1'b0);
    end
    check("t6_ce_ius", bus.O_IUS, 4'b0001);
    fetch(8'h4D);
    check_static("t6_ce_after");
    fetch(8'hED); fetch(8'h4D);
    check_static("t6_clean");

    // Randomized mix of requests, acknowledges and opcode streams
    for (int it = 0; it < 60; it++) begin
      bus.I_IEI = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: irq(NUM_CH'($urandom_range(1, 15)));
        1: inta();
        2: begin
          fetch(8'hED);
          fetch(($urandom_range(0, 1) != 0) ? 8'h4D : 8'h45);
        end
        default: fetch(ops[$urandom_range(0, 5)]);
      endcase
      check_static("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
